game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_pkg.sv | 32 +++
 rtl/game_sequencer_if.sv | 34 +++
 rtl/game_sequencer_btn_edge.sv | 24 ++
 rtl/game_sequencer.sv | 163 ++++++++++++++++
 tb/tb_game_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the artillery game sequencer: FSM states,
// shot result codes and saturating 3-bit health helpers.
package game_pkg;

    localparam int DEF_MAX_HEALTH = 3;
    localparam int DEF_MAX_ANGLE  = 9;

    typedef enum logic [2:0] {
        AIM,
        LAUNCH,
        FLIGHT,
        RESOLVE,
        GAME_OVER
    } state_e;

    typedef enum logic [2:0] {
        NONE,
        TARGET,
        OBSTACLE,
        POWERUP,
        OOB
    } result_e;

    function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
        return (v >= lim) ? lim : v + 3'd1;
    endfunction

    function automatic logic [2:0] sat_dec(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Button, projectile-datapath and status signals of the game sequencer.
// The slave modport is the sequencer side, master is the environment side.
interface game_sequencer_if;

    logic       btn_fire;
    logic       btn_up;
    logic       btn_down;
    logic       shot_active;
    logic       hit_target;
    logic       hit_obstacle;
    logic       hit_powerup;
    logic       out_of_bounds;
    logic       fire;
    logic [3:0] angle;
    logic       turn;
    logic [2:0] health_0;
    logic [2:0] health_1;
    logic       p_display;
    logic       game_over;
    logic       winner;

    modport slave (
        input  btn_fire, btn_up, btn_down, shot_active,
               hit_target, hit_obstacle, hit_powerup, out_of_bounds,
        output fire, angle, turn, health_0, health_1, p_display, game_over, winner
    );

    modport master (
        output btn_fire, btn_up, btn_down, shot_active,
               hit_target, hit_obstacle, hit_powerup, out_of_bounds,
        input  fire, angle, turn, health_0, health_1, p_display, game_over, winner
    );

endinterface

// File: rtl/game_sequencer_btn_edge.sv
// Registered rising-edge detector: one pulse per press, however long the button is held.
module btn_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= btn_i;
            rise_q <= btn_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/game_sequencer.sv
// Two-player turn sequencer: aim, launch, track the flight result, update health.
// Define SHOT_TIMEOUT_EN to add a FLIGHT watchdog that forces an out-of-bounds result.
module game_sequencer
    import game_pkg::*;
#(
    parameter int MAX_HEALTH     = DEF_MAX_HEALTH,
    parameter int MAX_ANGLE      = DEF_MAX_ANGLE,
    parameter int RESTART_CYCLES = 400,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input logic clk50,
    input logic rst,
    game_sequencer_if.slave bus
);

    localparam int         GO_W = $clog2(RESTART_CYCLES + 1);
    localparam logic [2:0] HMAX = 3'(MAX_HEALTH);
    localparam logic [3:0] AMAX = 4'(MAX_ANGLE);

    state_e      state_q;
    result_e     result_q;
    result_e     flight_res;
    logic [3:0]  angle_q;
    logic        turn_q;
    logic        fire_q;
    logic [2:0]  health_0_q, health_0_d;
    logic [2:0]  health_1_q, health_1_d;
    logic        p_display_q;
    logic        game_over_q;
    logic        winner_q;
    logic        shot_prev_q;
    logic [GO_W-1:0] go_cnt_q;
    logic        fire_rise, up_rise, down_rise;

`ifdef SHOT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
`endif

    btn_edge u_fire (.clk_i(clk50), .rst_i(rst), .btn_i(bus.btn_fire), .rise_o(fire_rise));
    btn_edge u_up   (.clk_i(clk50), .rst_i(rst), .btn_i(bus.btn_up),   .rise_o(up_rise));
    btn_edge u_down (.clk_i(clk50), .rst_i(rst), .btn_i(bus.btn_down), .rise_o(down_rise));

    // Highest-priority result seen this cycle; a dropped shot_active counts as out of bounds.
    always_comb begin
        flight_res = NONE;
        if (bus.hit_target)
            flight_res = TARGET;
        else if (bus.hit_obstacle)
            flight_res = OBSTACLE;
        else if (bus.hit_powerup && p_display_q)
            flight_res = POWERUP;
        else if (bus.out_of_bounds || (shot_prev_q && !bus.shot_active))
            flight_res = OOB;
`ifdef SHOT_TIMEOUT_EN
        if (flight_res == NONE && wd_q == WD_W'(TIMEOUT_CYCLES - 1))
            flight_res = OOB;
`endif
    end

    always_comb begin
        health_0_d = health_0_q;
        health_1_d = health_1_q;
        case (result_q)
            TARGET: begin
                if (turn_q) health_0_d = sat_dec(health_0_q);
                else        health_1_d = sat_dec(health_1_q);
            end
            POWERUP: begin
                if (turn_q) health_1_d = sat_inc(health_1_q, HMAX);
                else        health_0_d = sat_inc(health_0_q, HMAX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q     <= AIM;
            result_q    <= NONE;
            angle_q     <= 4'd0;
            turn_q      <= 1'b0;
            fire_q      <= 1'b0;
            health_0_q  <= HMAX;
            health_1_q  <= HMAX;
            p_display_q <= 1'b1;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            shot_prev_q <= 1'b0;
            go_cnt_q    <= '0;
`ifdef SHOT_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            fire_q      <= 1'b0;
            shot_prev_q <= bus.shot_active;
`ifdef SHOT_TIMEOUT_EN
            wd_q        <= '0;
`endif
            case (state_q)
                AIM: begin
                    if (up_rise && !down_rise && angle_q != AMAX)
                        angle_q <= angle_q + 4'd1;
                    else if (down_rise && !up_rise && angle_q != 4'd0)
                        angle_q <= angle_q - 4'd1;
                    if (fire_rise) begin
                        state_q <= LAUNCH;
                        fire_q  <= 1'b1;
                    end
                end
                LAUNCH: state_q <= FLIGHT;
                FLIGHT: begin
`ifdef SHOT_TIMEOUT_EN
                    wd_q <= wd_q + 1'b1;
`endif
                    if (flight_res != NONE) begin
                        result_q <= flight_res;
                        state_q  <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    health_0_q <= health_0_d;
                    health_1_q <= health_1_d;
                    turn_q     <= ~turn_q;
                    if (result_q == POWERUP)
                        p_display_q <= 1'b0;
                    if (health_0_d == 3'd0 || health_1_d == 3'd0) begin
                        state_q     <= GAME_OVER;
                        game_over_q <= 1'b1;
                        winner_q    <= (health_0_d == 3'd0);
                        go_cnt_q    <= '0;
                    end else begin
                        state_q <= AIM;
                    end
                end
                GAME_OVER: begin
                    if (go_cnt_q == GO_W'(RESTART_CYCLES - 1)) begin
                        state_q     <= AIM;
                        go_cnt_q    <= '0;
                        health_0_q  <= HMAX;
                        health_1_q  <= HMAX;
                        p_display_q <= 1'b1;
                        game_over_q <= 1'b0;
                        turn_q      <= 1'b0;
                    end else begin
                        go_cnt_q <= go_cnt_q + 1'b1;
                    end
                end
                default: state_q <= AIM;
            endcase
        end
    end

    assign bus.fire      = fire_q;
    assign bus.angle     = angle_q;
    assign bus.turn      = turn_q;
    assign bus.health_0  = health_0_q;
    assign bus.health_1  = health_1_q;
    assign bus.p_display = p_display_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer: aiming, launch timing, result priority,
// health bookkeeping, game-over restart and reset; SHOT_TIMEOUT_EN adds a watchdog step.
module tb_game_sequencer;
    import game_pkg::*;

    logic clk50 = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    game_sequencer_if bus();

    game_sequencer dut (
        .clk50 (clk50),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk50 = ~clk50;

    task automatic tick(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // which: 0 fire, 1 up, 2 down; a fire press from AIM leaves the FSM in FLIGHT
    task automatic press(input int which);
        bus.btn_fire = (which == 0);
        bus.btn_up   = (which == 1);
        bus.btn_down = (which == 2);
        tick(1);
        bus.btn_fire = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        tick(2);
    endtask

    // res bits: 0 target, 1 obstacle, 2 powerup, 3 out_of_bounds, pulsed for one cycle
    task automatic applyStimulus(input logic [3:0] res);
        bus.hit_target    = res[0];
        bus.hit_obstacle  = res[1];
        bus.hit_powerup   = res[2];
        bus.out_of_bounds = res[3];
        tick(1);
        bus.hit_target    = 1'b0;
        bus.hit_obstacle  = 1'b0;
        bus.hit_powerup   = 1'b0;
        bus.out_of_bounds = 1'b0;
    endtask

    task automatic runShot(input logic [3:0] res);
        press(0);
        applyStimulus(res);
        tick(1);
    endtask

    initial begin
        rst               = 1'b1;
        bus.btn_fire      = 1'b0;
        bus.btn_up        = 1'b0;
        bus.btn_down      = 1'b0;
        bus.shot_active   = 1'b0;
        bus.hit_target    = 1'b0;
        bus.hit_obstacle  = 1'b0;
        bus.hit_powerup   = 1'b0;
        bus.out_of_bounds = 1'b0;
        tick(2);
        rst = 1'b0;

        checkOutput("rst_state",  32'(dut.state_q), 32'(AIM));
        checkOutput("rst_angle",  32'(bus.angle), 0);
        checkOutput("rst_turn",   32'(bus.turn), 0);
        checkOutput("rst_fire",   32'(bus.fire), 0);
        checkOutput("rst_h0",     32'(bus.health_0), 3);
        checkOutput("rst_h1",     32'(bus.health_1), 3);
        checkOutput("rst_pdisp",  32'(bus.p_display), 1);
        checkOutput("rst_gover",  32'(bus.game_over), 0);
        checkOutput("rst_winner", 32'(bus.winner), 0);

        bus.btn_up = 1'b1;
        tick(20);
        bus.btn_up = 1'b0;
        tick(2);
        checkOutput("held_up_angle", 32'(bus.angle), 1);

        for (int i = 0; i < 10; i++) press(1);
        checkOutput("sat_max_angle", 32'(bus.angle), 9);
        press(2);
        checkOutput("down_angle", 32'(bus.angle), 8);

        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        tick(1);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        tick(2);
        checkOutput("up_down_angle", 32'(bus.angle), 8);

        bus.btn_fire = 1'b1;
        tick(1);
        checkOutput("fire_early", 32'(bus.fire), 0);
        bus.btn_fire = 1'b0;
        tick(1);
        checkOutput("fire_strobe", 32'(bus.fire), 1);
        checkOutput("launch_state", 32'(dut.state_q), 32'(LAUNCH));
        tick(1);
        checkOutput("fire_one_cycle", 32'(bus.fire), 0);
        checkOutput("flight_state", 32'(dut.state_q), 32'(FLIGHT));

        bus.btn_fire = 1'b1;
        tick(1);
        bus.btn_fire = 1'b0;
        tick(1);
        checkOutput("refire_ignored", 32'(bus.fire), 0);
        tick(1);
        press(1);
        checkOutput("angle_frozen", 32'(bus.angle), 8);
        checkOutput("still_flight", 32'(dut.state_q), 32'(FLIGHT));

        applyStimulus(4'b0101);
        checkOutput("resolve_state", 32'(dut.state_q), 32'(RESOLVE));
        tick(1);
        checkOutput("tgt_pu_h1", 32'(bus.health_1), 2);
        checkOutput("tgt_pu_pdisp", 32'(bus.p_display), 1);
        checkOutput("tgt_pu_turn", 32'(bus.turn), 1);
        checkOutput("back_to_aim", 32'(dut.state_q), 32'(AIM));

        runShot(4'b1000);
        checkOutput("oob1_turn", 32'(bus.turn), 0);
        checkOutput("oob1_h0", 32'(bus.health_0), 3);
        runShot(4'b0001);
        checkOutput("hit2_h1", 32'(bus.health_1), 1);
        runShot(4'b1000);
        checkOutput("oob2_turn", 32'(bus.turn), 0);
        runShot(4'b0001);
        checkOutput("hit3_h1", 32'(bus.health_1), 0);
        checkOutput("gover_set", 32'(bus.game_over), 1);
        checkOutput("gover_winner", 32'(bus.winner), 0);
        checkOutput("gover_state", 32'(dut.state_q), 32'(GAME_OVER));

        press(0);
        checkOutput("gover_fire_ignored", 32'(bus.fire), 0);
        tick(396);
        checkOutput("gover_hold_399", 32'(bus.game_over), 1);
        checkOutput("gover_state_399", 32'(dut.state_q), 32'(GAME_OVER));
        tick(1);
        checkOutput("restart_gover", 32'(bus.game_over), 0);
        checkOutput("restart_state", 32'(dut.state_q), 32'(AIM));
        checkOutput("restart_h0", 32'(bus.health_0), 3);
        checkOutput("restart_h1", 32'(bus.health_1), 3);
        checkOutput("restart_turn", 32'(bus.turn), 0);
        checkOutput("restart_pdisp", 32'(bus.p_display), 1);

        runShot(4'b0110);
        checkOutput("obst_pu_pdisp", 32'(bus.p_display), 1);
        checkOutput("obst_pu_turn", 32'(bus.turn), 1);
        runShot(4'b0100);
        checkOutput("pu_full_h1", 32'(bus.health_1), 3);
        checkOutput("pu_pdisp_clear", 32'(bus.p_display), 0);
        checkOutput("pu_turn", 32'(bus.turn), 0);

        press(0);
        applyStimulus(4'b0100);
        checkOutput("pu_hidden_ignored", 32'(dut.state_q), 32'(FLIGHT));
        applyStimulus(4'b0001);
        tick(1);
        checkOutput("late_hit_h1", 32'(bus.health_1), 2);
        checkOutput("late_hit_turn", 32'(bus.turn), 1);

        press(0);
        tick(50);
        checkOutput("silent_flight", 32'(dut.state_q), 32'(FLIGHT));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("midflight_rst_state", 32'(dut.state_q), 32'(AIM));
        checkOutput("midflight_rst_h1", 32'(bus.health_1), 3);
        checkOutput("midflight_rst_turn", 32'(bus.turn), 0);
        checkOutput("midflight_rst_pdisp", 32'(bus.p_display), 1);
        checkOutput("midflight_rst_angle", 32'(bus.angle), 0);

        bus.shot_active = 1'b1;
        press(0);
        bus.shot_active = 1'b0;
        tick(1);
        checkOutput("shot_drop_resolve", 32'(dut.state_q), 32'(RESOLVE));
        tick(1);
        checkOutput("shot_drop_turn", 32'(bus.turn), 1);
        checkOutput("shot_drop_h0", 32'(bus.health_0), 3);

`ifdef SHOT_TIMEOUT_EN
        press(0);
        tick(4094);
        checkOutput("wd_before_limit", 32'(dut.state_q), 32'(FLIGHT));
        tick(1);
        checkOutput("wd_resolve", 32'(dut.state_q), 32'(RESOLVE));
        tick(1);
        checkOutput("wd_turn", 32'(bus.turn), 0);
        checkOutput("wd_h0", 32'(bus.health_0), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
